// File: rtl/mux_n_seq_pkg.sv
// Shared definitions for the sequenced channel multiplexer: FSM state encoding
// and request-mode constants.
package mux_n_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n.sv
// Combinational CHANNELS-to-1 word selector over a flattened channel bus.
module mux_n #(
    parameter  int BITS     = 32,
    parameter  int CHANNELS = 8,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*BITS-1:0] data,
    input  logic [SELW-1:0]          sel,
    output logic [BITS-1:0]          word
);

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                word = data[k*BITS +: BITS];
            end
        end
    end

endmodule

// File: rtl/mux_n_seq.sv
// Request-driven channel multiplexer: snapshots all channels on start, then
// emits one word (direct) or every word in ascending order (scan) under out_ready.
module mux_n_seq
    import mux_n_seq_pkg::*;
#(
    parameter  int BITS     = 32,
    parameter  int CHANNELS = 8,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNELS*BITS-1:0] data_in,
    input  logic [SELW-1:0]          sel,
    input  logic                     mode,
    input  logic                     start,
    input  logic                     out_ready,
    output logic [BITS-1:0]          out,
    output logic                     out_valid,
    output logic [SELW-1:0]          out_idx,
    output logic                     busy,
    output logic                     done
);

    state_t                   state, state_nxt;
    logic [CHANNELS*BITS-1:0] snap;
    logic [SELW-1:0]          idx, idx_nxt;
    logic                     scan_q;
    logic                     load;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    idx_nxt   = (mode == MODE_SCAN) ? '0 : sel;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if ((scan_q == MODE_SCAN) && (idx != SELW'(CHANNELS - 1))) begin
                        idx_nxt = idx + SELW'(1);
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            snap   <= '0;
            scan_q <= MODE_DIRECT;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                snap   <= data_in;
                scan_q <= mode;
            end
        end
    end

    // idx never moves outside EMIT, so the selected word holds in IDLE/DONE
    // without a separate output register.
    mux_n #(
        .BITS    (BITS),
        .CHANNELS(CHANNELS)
    ) u_sel (
        .data(snap),
        .sel (idx),
        .word(out)
    );

    assign out_idx   = idx;
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mux_n_seq.sv
// Bench for mux_n_seq: transaction-queue reference model on the 32x8 instance,
// plus directed checks on 32x2 and 1x8 instances.
module tb_mux_n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, mode, out_ready;
    logic [2:0]   sel;
    logic [255:0] d0;
    logic [63:0]  d1;
    logic [7:0]   d2;

    logic [31:0] o0; logic v0; logic [2:0] i0; logic b0, dn0;
    logic [31:0] o1; logic v1; logic [0:0] i1; logic b1, dn1;
    logic [0:0]  o2; logic v2; logic [2:0] i2; logic b2, dn2;

    mux_n_seq #(.BITS(32), .CHANNELS(8)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(d0), .sel(sel), .mode(mode),
        .start(start), .out_ready(out_ready), .out(o0), .out_valid(v0),
        .out_idx(i0), .busy(b0), .done(dn0));

    mux_n_seq #(.BITS(32), .CHANNELS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(d1), .sel(sel[0]), .mode(mode),
        .start(start), .out_ready(out_ready), .out(o1), .out_valid(v1),
        .out_idx(i1), .busy(b1), .done(dn1));

    mux_n_seq #(.BITS(1), .CHANNELS(8)) u2 (
        .clk(clk), .rst_n(rst_n), .data_in(d2), .sel(sel), .mode(mode),
        .start(start), .out_ready(out_ready), .out(o2), .out_valid(v2),
        .out_idx(i2), .busy(b2), .done(dn2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a request becomes a queue of (index, word) pairs taken
    // from data_in at the accepting edge; the head is on out while pending.
    logic [31:0] mq_w[$];
    logic [2:0]  mq_i[$];
    logic        m_done = 1'b0;
    logic [31:0] m_lw   = '0;
    logic [2:0]  m_li   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_w.delete(); mq_i.delete();
            m_done = 1'b0; m_lw = '0; m_li = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (mq_w.size() != 0) begin
            if (out_ready) begin
                m_lw = mq_w.pop_front();
                m_li = mq_i.pop_front();
                if (mq_w.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            if (mode) begin
                for (int k = 0; k < 8; k++) begin
                    mq_w.push_back(d0[k*32 +: 32]);
                    mq_i.push_back(3'(k));
                end
            end else begin
                mq_w.push_back(d0[int'(sel)*32 +: 32]);
                mq_i.push_back(sel);
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic        ev;
        logic [31:0] ew;
        logic [2:0]  ei;
        ev = (mq_w.size() != 0);
        ew = ev ? mq_w[0] : m_lw;
        ei = ev ? mq_i[0] : m_li;
        chk("model_out",   o0,  ew);
        chk("model_valid", v0,  ev);
        chk("model_idx",   i0,  ei);
        chk("model_busy",  b0,  ev || m_done);
        chk("model_done",  dn0, m_done);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_exp, dones, cnt1, cnt2;
        logic found;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b0; sel = '0;
        for (int k = 0; k < 8; k++) d0[k*32 +: 32] = 32'hA000_0000 + k;
        d1 = {32'h5A5A_0001, 32'h5A5A_0000};
        d2 = 8'b1011_0010;

        // Reset values
        repeat (2) begin
            @(negedge clk);
            chk("rst_out", o0, 0); chk("rst_valid", v0, 0); chk("rst_idx", i0, 0);
            chk("rst_busy", b0, 0); chk("rst_done", dn0, 0);
            chk("rst_busy1", b1, 0); chk("rst_busy2", b2, 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("idle_busy", b0, 0); chk("idle_valid", v0, 0);
        end

        // Direct mode
        tick();
        sel = 3'd5; mode = 1'b0; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("dir_out", o0, 32'hA000_0005); chk("dir_idx", i0, 5);
        chk("dir_valid", v0, 1); chk("dir_done_early", dn0, 0);
        tick();
        @(negedge clk);
        chk("dir_done", dn0, 1); chk("dir_valid_done", v0, 0);
        chk("dir_busy_done", b0, 1); chk("dir_out_hold", o0, 32'hA000_0005);
        tick();
        @(negedge clk);
        chk("dir_busy_after", b0, 0); chk("dir_done_after", dn0, 0);

        // Scan with alternating out_ready
        tick();
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        k_exp = 0; dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (v0) begin
                chk("scan_word", o0, 32'hA000_0000 + k_exp);
                chk("scan_idx", i0, k_exp);
                if (out_ready) k_exp++;
            end
            if (dn0) dones++;
            tick();
            out_ready = ~out_ready;
        end
        chk("scan_count", k_exp, 8);
        chk("scan_dones", dones, 1);

        // Snapshot isolation and ignored start (in EMIT and in DONE)
        tick();
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        k_exp = 0; dones = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (v0) begin
                chk("snap_word", o0, 32'hA000_0000 + k_exp);
                k_exp++;
            end
            if (dn0) dones++;
            if (c == 1) d0 = '1;
            start = (c == 2) || dn0;
            tick();
            start = 1'b0;
        end
        chk("snap_count", k_exp, 8);
        chk("snap_dones", dones, 1);
        for (int k = 0; k < 8; k++) d0[k*32 +: 32] = 32'hA000_0000 + k;

        // Reset in the middle of a scan
        repeat (6) tick();
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (v0 && i0 == 3'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_reached_idx3", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", o0, 0); chk("mid_rst_valid", v0, 0); chk("mid_rst_idx", i0, 0);
        chk("mid_rst_busy", b0, 0); chk("mid_rst_done", dn0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        sel = 3'd2; mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("post_rst_out", o0, 32'hA000_0002); chk("post_rst_idx", i0, 2);
        chk("post_rst_valid", v0, 1);

        // Throughput and alternate sizes
        repeat (4) tick();
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        cnt1 = 0; cnt2 = 0; k_exp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("tp_valid0", v0, c < 8);
            chk("tp_valid1", v1, c < 2);
            chk("tp_valid2", v2, c < 8);
            if (v0) k_exp++;
            if (v1) begin
                chk("tp_word1", o1, d1[cnt1*32 +: 32]);
                chk("tp_idx1", i1, cnt1);
                cnt1++;
            end
            if (v2) begin
                chk("tp_word2", o2, d2[cnt2]);
                chk("tp_idx2", i2, cnt2);
                cnt2++;
            end
            tick();
        end
        chk("tp_count0", k_exp, 8);
        chk("tp_count1", cnt1, 2);
        chk("tp_count2", cnt2, 8);
        chk("tp_busy1_end", b1, 0);
        chk("tp_busy2_end", b2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
